// File: rtl/keypad_event_scanner_if.sv
// Key-event handshake between the keypad scanner (master) and the game's hit-check logic (slave).
interface keypad_event_scanner_if;
  logic       key_valid;
  logic       key_ready;
  logic [2:0] key_code;
  logic [7:0] key_onehot;

  modport master (
    output key_valid,
    output key_code,
    output key_onehot,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_onehot,
    output key_ready
  );
endinterface

// File: rtl/keypad_event_scanner.sv
// Synchronises and debounces eight raw buttons and emits one one-hot event per clean single-key press.
module keypad_event_scanner #(
  parameter int TICK_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic                           clk,
  input  logic                           RESET,
  input  logic [7:0]                     keypad,
  keypad_event_scanner_if.master         keyIf,
  output logic                           key_held,
  output logic                           multi_err,
  output logic                           overrun
);

  localparam int          CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0]  DB = 8'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  logic [7:0]    sync1_q, sync2_q;
  logic [CW-1:0] tickCnt_q, tickCnt_d;
  logic          tick;
  logic [7:0]    sample;
  logic          isOneHot, isMulti, isZero;
  logic [7:0]    cnt_q, cntInc;
  logic [7:0]    cand_q;
  state_t        state_q;
  logic          held_q;
  logic          multi_q;
  logic          valid_q;
  logic [2:0]    code_q;
  logic [7:0]    onehot_q;
  logic          overrun_q;
  logic          fireEvt;

  function automatic logic [2:0] keyIndex(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    tick      = (tickCnt_q == TICK_LAST);
    tickCnt_d = tick ? '0 : tickCnt_q + CW'(1);
    sample    = sync2_q;
    isZero    = (sample == 8'h00);
    isOneHot  = !isZero && ((sample & (sample - 8'd1)) == 8'h00);
    isMulti   = !isZero && !isOneHot;
    cntInc    = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    fireEvt   = 1'b0;
    if (tick) begin
      if (state_q == IDLE && isOneHot && DB == 8'd1) begin
        fireEvt = 1'b1;
      end else if (state_q == DEBOUNCE && sample == cand_q && cntInc == DB) begin
        fireEvt = 1'b1;
      end
    end
  end

  // The two-flop synchroniser is cleared by reset so a held key is re-debounced from scratch.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      tickCnt_q <= '0;
      multi_q   <= 1'b0;
    end else begin
      sync1_q   <= keypad;
      sync2_q   <= sync1_q;
      tickCnt_q <= tickCnt_d;
      if (tick) multi_q <= isMulti;
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      held_q  <= 1'b0;
    end else if (tick) begin
      case (state_q)
        IDLE: begin
          if (isOneHot) begin
            cand_q <= sample;
            cnt_q  <= 8'd1;
            if (DB == 8'd1) begin
              state_q <= PRESSED;
              held_q  <= 1'b1;
            end else begin
              state_q <= DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (sample == cand_q) begin
            cnt_q <= cntInc;
            if (cntInc == DB) begin
              state_q <= PRESSED;
              held_q  <= 1'b1;
            end
          end else begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        PRESSED: begin
          if (isZero) begin
            cnt_q <= 8'd1;
            if (DB == 8'd1) begin
              state_q <= IDLE;
              held_q  <= 1'b0;
            end else begin
              state_q <= RELEASE;
            end
          end
        end
        RELEASE: begin
          if (isZero) begin
            cnt_q <= cntInc;
            if (cntInc == DB) begin
              state_q <= IDLE;
              held_q  <= 1'b0;
            end
          end else begin
            cnt_q   <= '0;
            state_q <= PRESSED;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // A new event always wins over an accept in the same cycle; only an unacknowledged overwrite is an overrun.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      valid_q   <= 1'b0;
      code_q    <= '0;
      onehot_q  <= '0;
      overrun_q <= 1'b0;
    end else if (fireEvt) begin
      valid_q  <= 1'b1;
      code_q   <= keyIndex(sample);
      onehot_q <= sample;
      if (valid_q && !keyIf.key_ready) overrun_q <= 1'b1;
    end else if (valid_q && keyIf.key_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign keyIf.key_valid  = valid_q;
  assign keyIf.key_code   = code_q;
  assign keyIf.key_onehot = onehot_q;
  assign key_held         = held_q;
  assign multi_err        = multi_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Directed bench for the keypad scanner with TICK_DIV=4 and DEBOUNCE_TICKS=3.
module tb_keypad_event_scanner;

  logic       clk;
  logic       RESET;
  logic [7:0] keypad;
  logic       keyHeld;
  logic       multiErr;
  logic       overrunFlag;

  int vectorCount;
  int missCount;
  int evCount;
  int validCycles;
  logic [2:0] lastCode;
  int evBase;
  int validBase;

  keypad_event_scanner_if keyIf ();

  keypad_event_scanner #(
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (3)
  ) dut (
    .clk       (clk),
    .RESET     (RESET),
    .keypad    (keypad),
    .keyIf     (keyIf),
    .key_held  (keyHeld),
    .multi_err (multiErr),
    .overrun   (overrunFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake monitor: counts accepted events and cycles with key_valid high.
  always @(posedge clk) begin
    if (RESET && keyIf.key_valid) begin
      validCycles <= validCycles + 1;
      if (keyIf.key_ready) begin
        evCount  <= evCount + 1;
        lastCode <= keyIf.key_code;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] keys, input logic ready, input int cycles);
    keypad          = keys;
    keyIf.key_ready = ready;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    evCount     = 0;
    validCycles = 0;
    lastCode    = '0;
    RESET       = 1'b0;
    keypad      = 8'h00;
    keyIf.key_ready = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("rst_valid",   32'(keyIf.key_valid),  32'd0);
    checkOutput("rst_onehot",  32'(keyIf.key_onehot), 32'h00);
    checkOutput("rst_code",    32'(keyIf.key_code),   32'd0);
    checkOutput("rst_held",    32'(keyHeld),          32'd0);
    checkOutput("rst_multi",   32'(multiErr),         32'd0);
    checkOutput("rst_overrun", 32'(overrunFlag),      32'd0);
    RESET = 1'b1;

    // Short press of two ticks never debounces.
    applyStimulus(8'h01, 1'b1, 8);
    applyStimulus(8'h00, 1'b1, 20);
    checkOutput("short_events", 32'(evCount),            32'd0);
    checkOutput("short_onehot", 32'(keyIf.key_onehot),   32'h00);
    checkOutput("short_held",   32'(keyHeld),            32'd0);

    // Clean press of key 2.
    evBase = evCount; validBase = validCycles;
    applyStimulus(8'h04, 1'b1, 40);
    checkOutput("p1_events", 32'(evCount - evBase),        32'd1);
    checkOutput("p1_pulse",  32'(validCycles - validBase), 32'd1);
    checkOutput("p1_code",   32'(lastCode),                32'd2);
    checkOutput("p1_onehot", 32'(keyIf.key_onehot),        32'h04);
    checkOutput("p1_held",   32'(keyHeld),                 32'd1);
    applyStimulus(8'h00, 1'b1, 8);
    checkOutput("p1_held_rel", 32'(keyHeld), 32'd1);
    applyStimulus(8'h00, 1'b1, 12);
    checkOutput("p1_released",  32'(keyHeld),           32'd0);
    checkOutput("p1_onehot_kp", 32'(keyIf.key_onehot),  32'h04);
    checkOutput("p1_events_end", 32'(evCount - evBase), 32'd1);

    // Bouncing key 4 then stable.
    evBase = evCount;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(8'h10, 1'b1, 4);
      applyStimulus(8'h00, 1'b1, 4);
    end
    checkOutput("bounce_none", 32'(evCount - evBase), 32'd0);
    applyStimulus(8'h10, 1'b1, 30);
    checkOutput("bounce_events", 32'(evCount - evBase), 32'd1);
    checkOutput("bounce_code",   32'(lastCode),         32'd4);
    applyStimulus(8'h00, 1'b1, 20);

    // Two keys at once: flagged, never an event.
    evBase = evCount;
    applyStimulus(8'h81, 1'b1, 1);
    checkOutput("multi_early", 32'(multiErr), 32'd0);
    applyStimulus(8'h81, 1'b1, 39);
    checkOutput("multi_set",    32'(multiErr),          32'd1);
    checkOutput("multi_events", 32'(evCount - evBase),  32'd0);
    checkOutput("multi_held",   32'(keyHeld),           32'd0);
    applyStimulus(8'h00, 1'b1, 8);
    checkOutput("multi_clear", 32'(multiErr), 32'd0);

    // Consumer stalled: second event overwrites the first.
    applyStimulus(8'h01, 1'b0, 30);
    checkOutput("ovr_valid1", 32'(keyIf.key_valid), 32'd1);
    checkOutput("ovr_code1",  32'(keyIf.key_code),  32'd0);
    checkOutput("ovr_flag0",  32'(overrunFlag),     32'd0);
    applyStimulus(8'h00, 1'b0, 20);
    applyStimulus(8'h02, 1'b0, 30);
    checkOutput("ovr_valid2", 32'(keyIf.key_valid),  32'd1);
    checkOutput("ovr_code2",  32'(keyIf.key_code),   32'd1);
    checkOutput("ovr_onehot", 32'(keyIf.key_onehot), 32'h02);
    checkOutput("ovr_flag1",  32'(overrunFlag),      32'd1);
    applyStimulus(8'h02, 1'b1, 1);
    applyStimulus(8'h02, 1'b0, 2);
    checkOutput("ovr_accept", 32'(keyIf.key_valid), 32'd0);
    checkOutput("ovr_sticky", 32'(overrunFlag),     32'd1);
    applyStimulus(8'h00, 1'b1, 20);

    // Reset while debouncing key 3.
    applyStimulus(8'h08, 1'b1, 8);
    RESET = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_valid",   32'(keyIf.key_valid),  32'd0);
    checkOutput("mid_rst_onehot",  32'(keyIf.key_onehot), 32'h00);
    checkOutput("mid_rst_held",    32'(keyHeld),          32'd0);
    checkOutput("mid_rst_overrun", 32'(overrunFlag),      32'd0);
    RESET = 1'b1;
    evBase = evCount;
    applyStimulus(8'h08, 1'b1, 8);
    checkOutput("mid_rst_early", 32'(evCount - evBase), 32'd0);
    applyStimulus(8'h08, 1'b1, 12);
    checkOutput("mid_rst_event",  32'(evCount - evBase),  32'd1);
    checkOutput("mid_rst_code",   32'(lastCode),          32'd3);
    checkOutput("mid_rst_onehot2", 32'(keyIf.key_onehot), 32'h08);
    checkOutput("mid_rst_held2",  32'(keyHeld),           32'd1);
    applyStimulus(8'h00, 1'b1, 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
